// File: rtl/pix_lat_align.sv
// pix_lat_align -- latency-alignment buffer for packed pixel words plus
// forecast ZBT address generator.
//
// Each accepted word (in_valid) is written into a circular RAM of
// 2^LOGDEPTH words. Once the buffer holds `delay` words, every further
// accepted word releases the word accepted `delay` words earlier, one clock
// after acceptance. A three-state FSM (IDLE/FILL/RUN) primes the buffer.
// proc_pix_addr is a registered, forecast ZBT address derived from
// hcount/vcount.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   hcount, vcount      raster position used for the address forecast
//   in_word, in_valid   packed pixel word and its one-cycle accept strobe
//   delay               delay in words (0 = registered bypass)
//   flush               synchronous return to IDLE; wins over in_valid
//   out_word, out_valid delayed word (held) and its one-cycle strobe
//   proc_pix_addr       {vcount_f, hcount_f >> ADDR_SHIFT}, 1 clk latency
//   state               debug: 0=IDLE, 1=FILL, 2=RUN
//
// Build option: define PIX_LAT_ALIGN_BLANK_EN so that every accepted word
// that does not release real data produces an output strobe carrying
// BLANK_VALUE. Downstream then sees one output per input.
module pix_lat_align #(
   parameter int WIDTH      = 36,
   parameter int LOGDEPTH   = 10,
   parameter int ADDR_SHIFT = 1,
   parameter int FORECAST   = 8,
   parameter int HWRAP      = 1048,
   parameter int VLAST      = 805,
   parameter logic [WIDTH-1:0] BLANK_VALUE = '0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [10:0]         hcount,
   input  logic [9:0]          vcount,
   input  logic [WIDTH-1:0]    in_word,
   input  logic                in_valid,
   input  logic [LOGDEPTH-1:0] delay,
   input  logic                flush,
   output logic [WIDTH-1:0]    out_word,
   output logic                out_valid,
   output logic [18:0]         proc_pix_addr,
   output logic [1:0]          state
);

`ifdef PIX_LAT_ALIGN_BLANK_EN
   localparam bit BLANK_EN = 1'b1;
`else
   localparam bit BLANK_EN = 1'b0;
`endif

   localparam logic [11:0] HWRAP_X    = 12'(HWRAP);
   localparam logic [11:0] FORECAST_X = 12'(FORECAST);
   localparam logic [9:0]  VLAST_X    = 10'(VLAST);
   localparam logic [LOGDEPTH-1:0] ONE = LOGDEPTH'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [LOGDEPTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [LOGDEPTH-1:0] fill_cnt_q, fill_cnt_d;
   logic [LOGDEPTH-1:0] delay_q, delay_d;
   logic [LOGDEPTH-1:0] fill_inc, rd_ptr;
   logic                out_valid_q, out_valid_d;
   logic                out_sel_ram_q, out_sel_ram_d;
   logic [WIDTH-1:0]    byp_q, byp_d;
   logic [WIDTH-1:0]    ram_rd_q;
   logic [18:0]         addr_q, addr_d;
   logic                wr_en, ram_ld, emit;
   logic [11:0]         hcount_x, hcount_f;
   logic [9:0]          vcount_f;

   logic [WIDTH-1:0] mem [0:(1<<LOGDEPTH)-1];

   // Read slot for a releasing word. With delay_q = 2^LOGDEPTH-1 this is
   // wr_ptr+1, so read and write never share an address when delay_q > 0.
   assign rd_ptr = wr_ptr_q - delay_q;

   always_comb begin
      state_d       = state_q;
      wr_ptr_d      = wr_ptr_q;
      fill_cnt_d    = fill_cnt_q;
      delay_d       = delay_q;
      out_valid_d   = 1'b0;
      out_sel_ram_d = out_sel_ram_q;
      byp_d         = byp_q;
      wr_en         = 1'b0;
      ram_ld        = 1'b0;
      emit          = 1'b0;
      fill_inc      = fill_cnt_q + ONE;

      if (flush) begin
         // Pointer and RAM contents are kept; a colliding word is dropped.
         state_d    = ST_IDLE;
         fill_cnt_d = '0;
      end else if (in_valid) begin
         wr_en    = 1'b1;
         wr_ptr_d = wr_ptr_q + ONE;
         case (state_q)
            ST_IDLE: begin
               delay_d = delay;
               if (delay == '0) begin
                  state_d = ST_RUN;
                  emit    = 1'b1;
               end else begin
                  // A one-word delay is already primed by this word.
                  fill_cnt_d = ONE;
                  state_d    = (delay == ONE) ? ST_RUN : ST_FILL;
               end
            end
            ST_FILL, ST_RUN: begin
               if (delay != delay_q) begin
                  // Re-prime for the new delay; this word is stored only.
                  delay_d    = delay;
                  fill_cnt_d = ONE;
                  state_d    = (delay <= ONE) ? ST_RUN : ST_FILL;
               end else if (state_q == ST_FILL) begin
                  fill_cnt_d = fill_inc;
                  if (fill_inc == delay_q) state_d = ST_RUN;
               end else begin
                  emit = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase

         if (emit) begin
            out_valid_d = 1'b1;
            if (delay_d == '0) begin
               // Zero delay: register the incoming word directly.
               out_sel_ram_d = 1'b0;
               byp_d         = in_word;
            end else begin
               out_sel_ram_d = 1'b1;
               ram_ld        = 1'b1;
            end
         end else if (BLANK_EN) begin
            out_valid_d   = 1'b1;
            out_sel_ram_d = 1'b0;
            byp_d         = BLANK_VALUE;
         end
      end
   end

   // Address forecast: run FORECAST pixels ahead, wrapping into next line.
   always_comb begin
      hcount_x = {1'b0, hcount};
      if (hcount_x >= HWRAP_X) begin
         hcount_f = hcount_x - HWRAP_X;
         vcount_f = (vcount == VLAST_X) ? '0 : vcount + 10'd1;
      end else begin
         hcount_f = hcount_x + FORECAST_X;
         vcount_f = vcount;
      end
      addr_d = {vcount_f, 9'(hcount_f >> ADDR_SHIFT)};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         wr_ptr_q      <= '0;
         fill_cnt_q    <= '0;
         delay_q       <= '0;
         out_valid_q   <= 1'b0;
         out_sel_ram_q <= 1'b0;
         byp_q         <= '0;
         addr_q        <= '0;
      end else begin
         state_q       <= state_d;
         wr_ptr_q      <= wr_ptr_d;
         fill_cnt_q    <= fill_cnt_d;
         delay_q       <= delay_d;
         out_valid_q   <= out_valid_d;
         out_sel_ram_q <= out_sel_ram_d;
         byp_q         <= byp_d;
         addr_q        <= addr_d;
      end
   end

   // Plain dual-port RAM with registered read; no reset so it maps to block RAM.
   always_ff @(posedge clk) begin
      if (wr_en)  mem[wr_ptr_q] <= in_word;
      if (ram_ld) ram_rd_q      <= mem[rd_ptr];
   end

   assign out_word      = out_sel_ram_q ? ram_rd_q : byp_q;
   assign out_valid     = out_valid_q;
   assign proc_pix_addr = addr_q;
   assign state         = state_q;

endmodule

// File: tb/tb_pix_lat_align.sv
module tb_pix_lat_align;
   localparam int WIDTH    = 36;
   localparam int LOGDEPTH = 4;

   logic                clk = 1'b0;
   logic                reset;
   logic [10:0]         hcount;
   logic [9:0]          vcount;
   logic [WIDTH-1:0]    in_word;
   logic                in_valid;
   logic [LOGDEPTH-1:0] delay;
   logic                flush;
   logic [WIDTH-1:0]    out_word;
   logic                out_valid;
   logic [18:0]         proc_pix_addr;
   logic [1:0]          state;

   int n_cmp = 0;
   int n_err = 0;

   pix_lat_align #(.WIDTH(WIDTH), .LOGDEPTH(LOGDEPTH)) dut (
      .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
      .in_word(in_word), .in_valid(in_valid), .delay(delay), .flush(flush),
      .out_word(out_word), .out_valid(out_valid),
      .proc_pix_addr(proc_pix_addr), .state(state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle from a falling edge; outputs are sampled at the next one.
   task automatic cyc(input logic v, input logic [WIDTH-1:0] w);
      in_valid = v;
      in_word  = w;
      @(negedge clk);
   endtask

   task automatic do_flush();
      flush = 1'b1;
      cyc(1'b0, '0);
      flush = 1'b0;
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_word = '0; flush = 1'b0;
      delay = '0; hcount = '0; vcount = '0;
      repeat (3) @(negedge clk);
      chk("rst_state", 64'(state), 64'd0);
      chk("rst_vld",   64'(out_valid), 64'd0);
      chk("rst_word",  64'(out_word), 64'd0);
      chk("rst_addr",  64'(proc_pix_addr), 64'd0);
      reset = 1'b0;

      // Prime and run, delay 3: outputs 1,2,3 after words 4,5,6
      delay = 4'd3;
      for (int i = 0; i < 6; i++) begin
         cyc(1'b1, WIDTH'(i + 1));
         chk("prime_vld", 64'(out_valid), (i >= 3) ? 64'd1 : 64'd0);
         if (i >= 3) chk("prime_word", 64'(out_word), 64'(i - 2));
         if (i == 0) chk("prime_fill", 64'(state), 64'd1);
         if (i == 2) chk("prime_run",  64'(state), 64'd2);
      end
      cyc(1'b0, '0);
      chk("prime_idle_vld", 64'(out_valid), 64'd0);
      chk("prime_hold",     64'(out_word), 64'd3);

      // Bypass, delay 0
      do_flush();
      chk("byp_idle", 64'(state), 64'd0);
      delay = 4'd0;
      cyc(1'b1, WIDTH'('hA));
      chk("byp_vld_a",  64'(out_valid), 64'd1);
      chk("byp_word_a", 64'(out_word), 64'hA);
      chk("byp_state",  64'(state), 64'd2);
      cyc(1'b0, '0);
      chk("byp_gap_vld",  64'(out_valid), 64'd0);
      chk("byp_gap_hold", 64'(out_word), 64'hA);
      cyc(1'b1, WIDTH'('hB));
      chk("byp_vld_b",  64'(out_valid), 64'd1);
      chk("byp_word_b", 64'(out_word), 64'hB);
      cyc(1'b0, '0);

      // Delay change in RUN: 2 -> 4 at word 0x14
      do_flush();
      delay = 4'd2;
      for (int i = 0; i < 10; i++) begin
         if (i == 4) delay = 4'd4;
         cyc(1'b1, WIDTH'('h10 + i));
         chk("dchg_vld", 64'(out_valid), (i == 2 || i == 3 || i >= 8) ? 64'd1 : 64'd0);
         if (i == 2 || i == 3) chk("dchg_word2", 64'(out_word), 64'('h10 + i - 2));
         if (i >= 8)           chk("dchg_word4", 64'(out_word), 64'('h10 + i - 4));
         if (i == 4) chk("dchg_fill", 64'(state), 64'd1);
         if (i == 7) chk("dchg_run",  64'(state), 64'd2);
      end

      // Flush colliding with in_valid in RUN
      flush = 1'b1;
      cyc(1'b1, WIDTH'('h99));
      flush = 1'b0;
      chk("flush_state", 64'(state), 64'd0);
      chk("flush_vld",   64'(out_valid), 64'd0);
      cyc(1'b0, '0);
      chk("flush_vld2",  64'(out_valid), 64'd0);
      delay = 4'd2;
      for (int i = 0; i < 3; i++) cyc(1'b1, WIDTH'('h20 + i));
      chk("post_flush_vld",  64'(out_valid), 64'd1);
      chk("post_flush_word", 64'(out_word), 64'h20);
      cyc(1'b0, '0);

      // Maximum delay across pointer wrap
      do_flush();
      delay = 4'd15;
      for (int n = 0; n < 40; n++) begin
         cyc(1'b1, WIDTH'('h100 + n));
         chk("wrap_vld", 64'(out_valid), (n >= 15) ? 64'd1 : 64'd0);
         if (n >= 15) chk("wrap_word", 64'(out_word), 64'('h100 + n - 15));
      end
      cyc(1'b0, '0);

      // Asynchronous reset mid-operation
      #2 reset = 1'b1;
      #1;
      chk("arst_state", 64'(state), 64'd0);
      chk("arst_word",  64'(out_word), 64'd0);
      chk("arst_addr",  64'(proc_pix_addr), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      delay = 4'd3;
      cyc(1'b1, WIDTH'('h55));
      chk("arst_fill", 64'(state), 64'd1);
      chk("arst_vld",  64'(out_valid), 64'd0);
      cyc(1'b0, '0);

      // Address forecast
      hcount = 11'd100;  vcount = 10'd7;   cyc(1'b0, '0);
      chk("addr_plain", 64'(proc_pix_addr), 64'((7 << 9) | 54));
      hcount = 11'd1050; vcount = 10'd805; cyc(1'b0, '0);
      chk("addr_vwrap", 64'(proc_pix_addr), 64'd1);
      hcount = 11'd1048; vcount = 10'd10;  cyc(1'b0, '0);
      chk("addr_hwrap", 64'(proc_pix_addr), 64'(11 << 9));
      hcount = 11'd0;    vcount = 10'd805; cyc(1'b0, '0);
      chk("addr_vlast", 64'(proc_pix_addr), 64'((805 << 9) | 4));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
